// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared types and helpers for the data-memory arbiter.
//   size_e     - access size encoding (BYTE/HALF/WORD)
//   state_e    - arbiter FSM states
//   NPORTS_MAX - largest supported requester count
//   is_aligned - natural-alignment check for a size / byte offset pair
package dmem_arb_pkg;

  localparam int NPORTS_MAX = 8;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RMW  = 1'b1
  } state_e;

  // The unused size encoding 2'd3 is reported as misaligned so it never
  // touches memory.
  function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] off);
    logic ok;
    case (size)
      SZ_BYTE: ok = 1'b1;
      SZ_HALF: ok = (off[0] == 1'b0);
      SZ_WORD: ok = (off == 2'b00);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/dmem_lane.sv
// dmem_lane: combinational little-endian lane logic for a 32-bit word.
//   old_word_i - word currently in memory (also the load source)
//   wdata_i    - low-aligned store data
//   size_i     - access size (size_e encoding)
//   off_i      - byte offset addr[1:0]
//   unsigned_i - loads: zero-extend instead of sign-extend
//   merged_o   - old word with the store lane replaced
//   rdata_o    - extracted and extended load data
module dmem_lane
  import dmem_arb_pkg::*;
(
  input  logic [31:0] old_word_i,
  input  logic [31:0] wdata_i,
  input  logic [1:0]  size_i,
  input  logic [1:0]  off_i,
  input  logic        unsigned_i,
  output logic [31:0] merged_o,
  output logic [31:0] rdata_o
);

  // Store merge: replace only the addressed byte or halfword lane.
  always_comb begin
    merged_o = old_word_i;
    case (size_i)
      SZ_BYTE: merged_o[{off_i, 3'b000} +: 8]     = wdata_i[7:0];
      SZ_HALF: merged_o[{off_i[1], 4'b0000} +: 16] = wdata_i[15:0];
      SZ_WORD: merged_o = wdata_i;
      default: merged_o = old_word_i;
    endcase
  end

  // Load extract: pick the lane, then sign- or zero-extend it.
  always_comb begin
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    byte_v = old_word_i[{off_i, 3'b000} +: 8];
    half_v = old_word_i[{off_i[1], 4'b0000} +: 16];
    case (size_i)
      SZ_BYTE: rdata_o = unsigned_i ? {24'd0, byte_v} : {{24{byte_v[7]}}, byte_v};
      SZ_HALF: rdata_o = unsigned_i ? {16'd0, half_v} : {{16{half_v[15]}}, half_v};
      SZ_WORD: rdata_o = old_word_i;
      default: rdata_o = 32'd0;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin sharing of a single-port 128x32 data memory.
//   clk_i, reset_i             - clock, synchronous active-high reset
//   req_*_i / req_ready_o      - per-port request channel (valid/ready)
//   rsp_valid_o/rdata_o/err_o  - per-port one-cycle registered response
//   mem_we_o/mem_a_o/mem_wd_o  - to dmem WE/A/WD
//   mem_rd_i                   - from dmem RD (combinational read)
// Sub-word stores take an extra RMW cycle because dmem writes whole words.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int NPORTS = 2
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic [NPORTS-1:0]       req_valid_i,
  output logic [NPORTS-1:0]       req_ready_o,
  input  logic [NPORTS-1:0]       req_we_i,
  input  logic [NPORTS-1:0][1:0]  req_size_i,
  input  logic [NPORTS-1:0]       req_unsigned_i,
  input  logic [NPORTS-1:0][31:0] req_addr_i,
  input  logic [NPORTS-1:0][31:0] req_wdata_i,
  output logic [NPORTS-1:0]       rsp_valid_o,
  output logic [NPORTS-1:0][31:0] rsp_rdata_o,
  output logic [NPORTS-1:0]       rsp_err_o,
  output logic                    mem_we_o,
  output logic [31:0]             mem_a_o,
  output logic [31:0]             mem_wd_o,
  input  logic [31:0]             mem_rd_i
);

  localparam int PW = (NPORTS > 1) ? $clog2(NPORTS) : 1;
  // Last grant resets to the highest port so port 0 is first in line.
  localparam logic [PW-1:0] LAST_RST = PW'(NPORTS - 1);

  state_e                    state_q, state_d;
  logic [PW-1:0]             last_grant_q, last_grant_d;
  logic [PW-1:0]             rmw_port_q, rmw_port_d;
  logic [31:0]               rmw_addr_q, rmw_addr_d;
  logic [31:0]               rmw_word_q, rmw_word_d;
  logic [NPORTS-1:0]         rsp_valid_q, rsp_valid_d;
  logic [NPORTS-1:0][31:0]   rsp_rdata_q, rsp_rdata_d;
  logic [NPORTS-1:0]         rsp_err_q, rsp_err_d;

  logic                      gnt_found_s;
  logic [PW-1:0]             gnt_idx_s;
  logic                      sel_we_s, sel_unsigned_s, sel_aligned_s;
  logic [1:0]                sel_size_s;
  logic [31:0]               sel_addr_s, sel_wdata_s;
  logic [31:0]               lane_merged_s, lane_rdata_s;

  // Round-robin search starting one past the last granted port.
  always_comb begin
    int   cand_v;
    logic hit_v;
    gnt_found_s = 1'b0;
    gnt_idx_s   = {PW{1'b0}};
    for (int k = 1; k <= NPORTS; k++) begin
      cand_v      = (int'(last_grant_q) + k) % NPORTS;
      hit_v       = req_valid_i[cand_v] && !gnt_found_s;
      gnt_idx_s   = hit_v ? PW'(cand_v) : gnt_idx_s;
      gnt_found_s = gnt_found_s | hit_v;
    end
  end

  assign sel_we_s       = req_we_i[gnt_idx_s];
  assign sel_unsigned_s = req_unsigned_i[gnt_idx_s];
  assign sel_size_s     = req_size_i[gnt_idx_s];
  assign sel_addr_s     = req_addr_i[gnt_idx_s];
  assign sel_wdata_s    = req_wdata_i[gnt_idx_s];
  assign sel_aligned_s  = is_aligned(sel_size_s, sel_addr_s[1:0]);

  // mem_rd_i always reflects the selected address in IDLE, so one lane
  // instance serves both load extraction and store merging.
  dmem_lane u_lane (
    .old_word_i (mem_rd_i),
    .wdata_i    (sel_wdata_s),
    .size_i     (sel_size_s),
    .off_i      (sel_addr_s[1:0]),
    .unsigned_i (sel_unsigned_s),
    .merged_o   (lane_merged_s),
    .rdata_o    (lane_rdata_s)
  );

  // FSM next state, memory pins, accept strobe and next response values.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    rmw_port_d   = rmw_port_q;
    rmw_addr_d   = rmw_addr_q;
    rmw_word_d   = rmw_word_q;
    rsp_valid_d  = {NPORTS{1'b0}};
    rsp_rdata_d  = '0;
    rsp_err_d    = {NPORTS{1'b0}};
    req_ready_o  = {NPORTS{1'b0}};
    mem_we_o     = 1'b0;
    mem_a_o      = 32'd0;
    mem_wd_o     = 32'd0;
    case (state_q)
      ST_IDLE: begin
        if (gnt_found_s && !reset_i) begin
          req_ready_o[gnt_idx_s] = 1'b1;
          last_grant_d           = gnt_idx_s;
          if (!sel_aligned_s) begin
            rsp_valid_d[gnt_idx_s] = 1'b1;
            rsp_err_d[gnt_idx_s]   = 1'b1;
          end else if (!sel_we_s) begin
            mem_a_o                  = sel_addr_s;
            rsp_valid_d[gnt_idx_s]   = 1'b1;
            rsp_rdata_d[gnt_idx_s]   = lane_rdata_s;
          end else if (sel_size_s == SZ_WORD) begin
            mem_we_o               = 1'b1;
            mem_a_o                = sel_addr_s;
            mem_wd_o               = sel_wdata_s;
            rsp_valid_d[gnt_idx_s] = 1'b1;
          end else begin
            // Read phase of read-modify-write: capture the merged word.
            mem_a_o    = sel_addr_s;
            rmw_addr_d = sel_addr_s;
            rmw_word_d = lane_merged_s;
            rmw_port_d = gnt_idx_s;
            state_d    = ST_RMW;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RMW: begin
        if (!reset_i) begin
          mem_we_o                = 1'b1;
          mem_a_o                 = rmw_addr_q;
          mem_wd_o                = rmw_word_q;
          rsp_valid_d[rmw_port_q] = 1'b1;
        end else begin
          mem_we_o = 1'b0;
        end
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, arbitration pointer, RMW latches and response registers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= ST_IDLE;
      last_grant_q <= LAST_RST;
      rmw_port_q   <= {PW{1'b0}};
      rmw_addr_q   <= 32'd0;
      rmw_word_q   <= 32'd0;
      rsp_valid_q  <= {NPORTS{1'b0}};
      rsp_rdata_q  <= '0;
      rsp_err_q    <= {NPORTS{1'b0}};
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      rmw_port_q   <= rmw_port_d;
      rmw_addr_q   <= rmw_addr_d;
      rmw_word_q   <= rmw_word_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_rdata_q  <= rsp_rdata_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign rsp_err_o   = rsp_err_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed, scoreboard-checked bench for dmem_arbiter with
// a behavioural 128x32 dmem attached to the memory pins.
module tb_dmem_arbiter;
  import dmem_arb_pkg::*;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [1:0]       req_valid = 2'b00;
  logic [1:0]       req_ready;
  logic [1:0]       req_we = 2'b00;
  logic [1:0][1:0]  req_size = '0;
  logic [1:0]       req_unsigned = 2'b00;
  logic [1:0][31:0] req_addr = '0;
  logic [1:0][31:0] req_wdata = '0;
  logic [1:0]       rsp_valid;
  logic [1:0][31:0] rsp_rdata;
  logic [1:0]       rsp_err;
  logic             mem_we;
  logic [31:0]      mem_a, mem_wd, mem_rd;

  logic [31:0] mem [0:127];
  logic        pre_en = 1'b0;
  logic [6:0]  pre_idx = 7'd0;
  logic [31:0] pre_val = 32'd0;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  typedef struct {
    int          port;
    logic [31:0] rdata;
    logic        err;
    int          due;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dmem_arbiter #(.NPORTS(2)) dut (
    .clk_i          (clk),
    .reset_i        (reset),
    .req_valid_i    (req_valid),
    .req_ready_o    (req_ready),
    .req_we_i       (req_we),
    .req_size_i     (req_size),
    .req_unsigned_i (req_unsigned),
    .req_addr_i     (req_addr),
    .req_wdata_i    (req_wdata),
    .rsp_valid_o    (rsp_valid),
    .rsp_rdata_o    (rsp_rdata),
    .rsp_err_o      (rsp_err),
    .mem_we_o       (mem_we),
    .mem_a_o        (mem_a),
    .mem_wd_o       (mem_wd),
    .mem_rd_i       (mem_rd)
  );

  // dmem model: combinational read, clocked word write decoding A[8:2].
  assign mem_rd = mem[mem_a[8:2]];
  always @(posedge clk) begin
    if (pre_en) mem[pre_idx] <= pre_val;
    else if (mem_we) mem[mem_a[8:2]] <= mem_wd;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [6:0] idx, input logic [31:0] val);
    pre_en = 1'b1; pre_idx = idx; pre_val = val;
    @(posedge clk); #1;
    pre_en = 1'b0;
  endtask

  task automatic set_req(input int p, input logic we, input logic [1:0] sz,
                         input logic uns, input logic [31:0] addr, input logic [31:0] wd);
    req_valid[p] = 1'b1; req_we[p] = we; req_size[p] = sz;
    req_unsigned[p] = uns; req_addr[p] = addr; req_wdata[p] = wd;
  endtask

  // Present a request, wait (bounded) for acceptance, queue the expected
  // response. Returns at #1 after the accepting edge with valid dropped.
  task automatic do_req(input int p, input logic we, input logic [1:0] sz, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] exp_rd, input logic exp_err, input logic sub,
                        output int acc_cyc);
    logic got;
    exp_t e;
    got = 1'b0;
    acc_cyc = -1;
    set_req(p, we, sz, uns, addr, wd);
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      if (req_ready[p]) begin
        got = 1'b1;
        acc_cyc = cyc;
        e.port = p; e.rdata = exp_rd; e.err = exp_err; e.due = cyc + (sub ? 2 : 1);
        sb.push_back(e);
      end
    end
    chk("accept", {63'd0, got}, 64'd1);
    @(posedge clk); #1;
    req_valid[p] = 1'b0;
  endtask

  // Response monitor: pops the scoreboard on every response pulse.
  always @(negedge clk) begin
    exp_t e;
    if (rsp_valid !== 2'b00) begin
      if (sb.size() == 0) begin
        chk("unexpected_rsp", {62'd0, rsp_valid}, 64'd0);
      end else begin
        e = sb.pop_front();
        chk("rsp_port", {62'd0, rsp_valid}, 64'd1 << e.port);
        chk("rsp_cycle", 64'(cyc), 64'(e.due));
        chk("rsp_rdata", {32'd0, rsp_rdata[e.port]}, {32'd0, e.rdata});
        chk("rsp_err", {63'd0, rsp_err[e.port]}, {63'd0, e.err});
      end
    end else if (sb.size() != 0 && cyc > sb[0].due) begin
      e = sb.pop_front();
      chk("rsp_missing", {62'd0, rsp_valid}, 64'd1 << e.port);
    end
  end

  initial begin
    int acc;
    int c0;
    logic got;

    // Reset with requests present: nothing accepted, no memory write.
    preload(7'd4, 32'hA1B2C3D4);
    preload(7'd8, 32'h12345678);
    preload(7'd16, 32'h00000000);
    set_req(0, 1'b1, SZ_WORD, 1'b0, 32'h10, 32'h0BADF00D);
    set_req(1, 1'b0, SZ_WORD, 1'b0, 32'h20, 32'd0);
    @(negedge clk);
    chk("reset_ready", {62'd0, req_ready}, 64'd0);
    chk("reset_mem_we", {63'd0, mem_we}, 64'd0);
    chk("reset_rsp_valid", {62'd0, rsp_valid}, 64'd0);
    chk("reset_rsp_err", {62'd0, rsp_err}, 64'd0);
    chk("reset_rsp_rdata", rsp_rdata, 64'd0);
    chk("reset_mem_kept", {32'd0, mem[4]}, {32'd0, 32'hA1B2C3D4});
    req_valid = 2'b00;
    @(posedge clk); #1;
    reset = 1'b0;

    // Port 1 alone is granted in the very first cycle after reset.
    set_req(1, 1'b0, SZ_WORD, 1'b0, 32'h20, 32'd0);
    @(negedge clk);
    chk("p1_first_grant", {62'd0, req_ready}, 64'd2);
    if (req_ready[1]) sb.push_back('{1, 32'h12345678, 1'b0, cyc + 1});
    @(posedge clk); #1;
    req_valid = 2'b00;

    // Loads with lane extraction and extension, back to back.
    do_req(0, 1'b0, SZ_WORD, 1'b0, 32'h10, 32'd0, 32'hA1B2C3D4, 1'b0, 1'b0, acc);
    do_req(0, 1'b0, SZ_BYTE, 1'b0, 32'h13, 32'd0, 32'hFFFFFFA1, 1'b0, 1'b0, acc);
    do_req(0, 1'b0, SZ_BYTE, 1'b1, 32'h13, 32'd0, 32'h000000A1, 1'b0, 1'b0, acc);
    do_req(0, 1'b0, SZ_BYTE, 1'b0, 32'h10, 32'd0, 32'hFFFFFFD4, 1'b0, 1'b0, acc);
    do_req(1, 1'b0, SZ_HALF, 1'b0, 32'h12, 32'd0, 32'hFFFFA1B2, 1'b0, 1'b0, acc);
    do_req(1, 1'b0, SZ_HALF, 1'b1, 32'h10, 32'd0, 32'h0000C3D4, 1'b0, 1'b0, acc);

    // Byte store RMW: blocks one cycle, then a load sees the merged word.
    do_req(0, 1'b1, SZ_BYTE, 1'b0, 32'h11, 32'h0000005A, 32'd0, 1'b0, 1'b1, acc);
    set_req(1, 1'b0, SZ_WORD, 1'b0, 32'h10, 32'd0);
    @(negedge clk);
    c0 = cyc;
    chk("rmw_blocks_accept", {62'd0, req_ready}, 64'd0);
    do_req(1, 1'b0, SZ_WORD, 1'b0, 32'h10, 32'd0, 32'hA1B25AD4, 1'b0, 1'b0, acc);
    chk("post_rmw_accept_cycle", 64'(acc), 64'(c0 + 1));
    chk("mem_after_byte", {32'd0, mem[4]}, {32'd0, 32'hA1B25AD4});
    do_req(0, 1'b1, SZ_HALF, 1'b0, 32'h12, 32'h0000BEEF, 32'd0, 1'b0, 1'b1, acc);
    do_req(0, 1'b0, SZ_WORD, 1'b0, 32'h10, 32'd0, 32'hBEEF5AD4, 1'b0, 1'b0, acc);
    chk("mem_after_half", {32'd0, mem[4]}, {32'd0, 32'hBEEF5AD4});

    // Misaligned requests: accepted with error, no write.
    do_req(0, 1'b0, SZ_HALF, 1'b0, 32'h21, 32'd0, 32'd0, 1'b1, 1'b0, acc);
    do_req(1, 1'b1, SZ_WORD, 1'b0, 32'h22, 32'hCAFEF00D, 32'd0, 1'b1, 1'b0, acc);
    repeat (2) @(posedge clk);
    #1;
    chk("misaligned_no_write", {32'd0, mem[8]}, {32'd0, 32'h12345678});

    // Word store then load of the same word on consecutive cycles.
    do_req(0, 1'b1, SZ_WORD, 1'b0, 32'h40, 32'hDEADBEEF, 32'd0, 1'b0, 1'b0, c0);
    do_req(1, 1'b0, SZ_WORD, 1'b0, 32'h40, 32'd0, 32'hDEADBEEF, 1'b0, 1'b0, acc);
    chk("store_load_b2b", 64'(acc), 64'(c0 + 1));

    // Both ports continuously valid: strict alternation, one per cycle.
    set_req(0, 1'b0, SZ_WORD, 1'b0, 32'h10, 32'd0);
    set_req(1, 1'b0, SZ_WORD, 1'b0, 32'h40, 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rr_grant", {62'd0, req_ready}, (i % 2 == 0) ? 64'd1 : 64'd2);
      if (i % 2 == 0) sb.push_back('{0, 32'hBEEF5AD4, 1'b0, cyc + 1});
      else sb.push_back('{1, 32'hDEADBEEF, 1'b0, cyc + 1});
      @(posedge clk); #1;
    end
    req_valid = 2'b00;
    repeat (2) @(posedge clk);
    #1;

    // Reset during RMW: write abandoned, no response, port 0 first after.
    set_req(0, 1'b1, SZ_BYTE, 1'b0, 32'h41, 32'h00000077);
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      got = req_ready[0];
    end
    chk("rmw_reset_accept", {63'd0, got}, 64'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    req_valid = 2'b00;
    @(posedge clk); #1;
    chk("rmw_reset_mem", {32'd0, mem[16]}, {32'd0, 32'hDEADBEEF});
    @(negedge clk);
    chk("rmw_reset_no_rsp", {62'd0, rsp_valid}, 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    set_req(0, 1'b0, SZ_WORD, 1'b0, 32'h40, 32'd0);
    set_req(1, 1'b0, SZ_WORD, 1'b0, 32'h10, 32'd0);
    @(negedge clk);
    chk("post_reset_grant", {62'd0, req_ready}, 64'd1);
    if (req_ready[0]) sb.push_back('{0, 32'hDEADBEEF, 1'b0, cyc + 1});
    @(posedge clk); #1;
    req_valid = 2'b00;

    repeat (4) @(negedge clk);
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
